latency_credit_queue: RTL and testbench

- Downstream companion to the fixed-latency shift-register delay line; that stage cannot stall.
- Gates issue into the delay line with a credit counter and captures delayed results in a DEPTH-entry first-word-fall-through FIFO.
- The consumer may apply out_ready backpressure without losing data.
- Issue, the delay line and the queue form a complete non-stalling-pipe wrapper.

---
 rtl/latency_pkg.sv | 12 +
 rtl/latency_credit_queue_fwft_fifo.sv | 69 ++++++
 rtl/latency_credit_queue.sv | 71 +++++++
 tb/tb_latency_credit_queue.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/latency_pkg.sv
// rtl/latency_pkg.sv - shared defaults and width helper for the latency credit queue
package latency_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 8;

   // Width needed to hold the values 0..n inclusive.
   function automatic int clog2_p1(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/latency_credit_queue_fwft_fifo.sv
// rtl/latency_credit_queue_fwft_fifo.sv - first-word-fall-through result FIFO with sticky overflow flag
module fwft_fifo
   import latency_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   localparam int CW = clog2_p1(DEPTH),
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic [CW-1:0]    count_o,
   output logic             err_overflow_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             full, empty, pop_fire, push_fire;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign pop_fire  = pop_i && !empty;
   // A simultaneous pop frees the slot being written, so a full FIFO still accepts.
   assign push_fire = push_i && (!full || pop_fire);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_fire)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_fire && !pop_fire)      count_d = count_q + 1'b1;
      else if (pop_fire && !push_fire) count_d = count_q - 1'b1;
      if (push_i && !push_fire) ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_fire) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign valid_o        = !empty;
   assign data_o         = mem_q[rd_ptr_q];
   assign count_o        = count_q;
   assign err_overflow_o = ovf_q;

endmodule

// File: rtl/latency_credit_queue.sv
// rtl/latency_credit_queue.sv - credit-gated issue plus result capture queue behind a non-stalling delay line
module latency_credit_queue
   import latency_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   localparam int CW = clog2_p1(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic             res_valid,
   input  logic [WIDTH-1:0] res_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CW-1:0]    credits,
   output logic [CW-1:0]    count,
   output logic             err_overflow,
   output logic             err_unexpected
);

   logic [CW-1:0] credits_q, credits_d;
   logic          unx_q, unx_d;
   logic          issue_fire, pop_fire, unexpected_hit;
   logic [CW:0]   committed;

   fwft_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk            (clk),
      .rst            (rst),
      .push_i         (res_valid),
      .push_data_i    (res_data),
      .pop_i          (out_ready),
      .valid_o        (out_valid),
      .data_o         (out_data),
      .count_o        (count),
      .err_overflow_o (err_overflow)
   );

   assign issue_ready = (credits_q != '0);
   assign issue_fire  = issue_valid && issue_ready;
   assign pop_fire    = out_valid && out_ready;

   // in_flight = DEPTH - credits - count; nothing is in flight once credits+count reach DEPTH.
   assign committed      = {1'b0, credits_q} + {1'b0, count};
   assign unexpected_hit = res_valid && (committed >= (CW+1)'(DEPTH));

   always_comb begin
      credits_d = credits_q;
      unx_d     = unx_q | unexpected_hit;
      if (issue_fire && !pop_fire)
         credits_d = credits_q - 1'b1;
      else if (pop_fire && !issue_fire && credits_q != CW'(DEPTH))
         credits_d = credits_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         credits_q <= CW'(DEPTH);
         unx_q     <= 1'b0;
      end else begin
         credits_q <= credits_d;
         unx_q     <= unx_d;
      end
   end

   assign credits        = credits_q;
   assign err_unexpected = unx_q;

endmodule

// File: tb/tb_latency_credit_queue.sv
// tb/tb_latency_credit_queue.sv - directed and random checks of latency_credit_queue behind a 5-stage delay line
module tb_latency_credit_queue;

   localparam int DEPTH = 8;
   localparam int WIDTH = 8;
   localparam int LEN   = 5;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             issue_valid, issue_ready;
   logic             res_valid;
   logic [WIDTH-1:0] res_data;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [CW-1:0]    credits, count;
   logic             err_overflow, err_unexpected;

   always #5 clk = ~clk;

   latency_credit_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .issue_valid    (issue_valid),
      .issue_ready    (issue_ready),
      .res_valid      (res_valid),
      .res_data       (res_data),
      .out_valid      (out_valid),
      .out_data       (out_data),
      .out_ready      (out_ready),
      .credits        (credits),
      .count          (count),
      .err_overflow   (err_overflow),
      .err_unexpected (err_unexpected)
   );

   // Delay line stand-in and injection source.
   logic             dl_v [LEN];
   logic [WIDTH-1:0] dl_d [LEN];
   logic [WIDTH-1:0] issue_data;
   logic             inj_valid;
   logic [WIDTH-1:0] inj_data;

   // Reference model: outstanding credits, ops still in the delay line, queued results.
   int               m_credits, m_inflight, m_fires;
   logic [WIDTH-1:0] m_q [$];
   logic             m_ovf, m_unx, model_on;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      check("m_issue_ready", 32'(issue_ready), 32'(m_credits != 0));
      check("m_credits", 32'(credits), 32'(m_credits));
      check("m_count", 32'(count), 32'(m_q.size()));
      check("m_out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check("m_out_data", 32'(out_data), 32'(m_q[0]));
      check("m_err_overflow", 32'(err_overflow), 32'(m_ovf));
      check("m_err_unexpected", 32'(err_unexpected), 32'(m_unx));
   endtask

   // One clock cycle: present delay-line output, check, clock, advance model and delay line.
   task automatic tick();
      logic m_fire, m_pop, push_ok, rv;
      logic [WIDTH-1:0] rd;
      res_valid = inj_valid | dl_v[LEN-1];
      res_data  = inj_valid ? inj_data : dl_d[LEN-1];
      #1;
      if (model_on) check_model();
      rv     = res_valid;
      rd     = res_data;
      m_fire = issue_valid && (m_credits != 0);
      m_pop  = out_ready && (m_q.size() != 0);
      @(posedge clk);
      if (rst) begin
         m_credits  = DEPTH;
         m_inflight = 0;
         m_q.delete();
         m_ovf = 1'b0;
         m_unx = 1'b0;
         for (int i = 0; i < LEN; i++) begin
            dl_v[i] = 1'b0;
            dl_d[i] = '0;
         end
      end else begin
         if (rv && m_inflight == 0) m_unx = 1'b1;
         if (rv && m_inflight > 0) m_inflight--;
         push_ok = rv && (m_q.size() < DEPTH || m_pop);
         if (rv && !push_ok) m_ovf = 1'b1;
         if (m_pop) void'(m_q.pop_front());
         if (push_ok) m_q.push_back(rd);
         if (m_fire && !m_pop) m_credits--;
         else if (m_pop && !m_fire && m_credits < DEPTH) m_credits++;
         for (int i = LEN - 1; i > 0; i--) begin
            dl_v[i] = dl_v[i-1];
            dl_d[i] = dl_d[i-1];
         end
         dl_v[0] = m_fire;
         dl_d[0] = issue_data;
         if (m_fire) begin
            m_inflight++;
            m_fires++;
            issue_data = issue_data + 1'b1;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      int pops;
      rst         = 1'b1;
      issue_valid = 1'b0;
      out_ready   = 1'b0;
      inj_valid   = 1'b0;
      inj_data    = '0;
      issue_data  = '0;
      res_valid   = 1'b0;
      res_data    = '0;
      model_on    = 1'b0;
      m_fires     = 0;
      for (int i = 0; i < LEN; i++) begin
         dl_v[i] = 1'b0;
         dl_d[i] = '0;
      end
      @(negedge clk);
      tick();
      tick();
      rst      = 1'b0;
      model_on = 1'b1;

      check("rst_credits", 32'(credits), 32'(DEPTH));
      check("rst_count", 32'(count), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_issue_ready", 32'(issue_ready), 1);
      check("rst_flags", {30'd0, err_overflow, err_unexpected}, 0);

      // Single op: out_valid appears in the sixth cycle after the issue cycle.
      issue_valid = 1'b1;
      issue_data  = 8'h3C;
      out_ready   = 1'b1;
      tick();
      issue_valid = 1'b0;
      check("single_credits_dec", 32'(credits), 7);
      repeat (4) tick();
      check("single_not_early", 32'(out_valid), 0);
      tick();
      check("single_out_valid", 32'(out_valid), 1);
      check("single_out_data", 32'(out_data), 32'h3C);
      tick();
      check("single_credits_back", 32'(credits), 8);
      check("single_drained", 32'(out_valid), 0);

      // Backpressure fill, overflow injection at count=8, ordered drain.
      out_ready   = 1'b0;
      issue_valid = 1'b1;
      issue_data  = 8'h00;
      m_fires     = 0;
      repeat (20) tick();
      check("fill_fires", 32'(m_fires), 8);
      check("fill_issue_ready", 32'(issue_ready), 0);
      check("fill_count", 32'(count), 8);
      check("fill_no_ovf", 32'(err_overflow), 0);
      issue_valid = 1'b0;
      inj_valid   = 1'b1;
      inj_data    = 8'h55;
      tick();
      inj_valid   = 1'b0;
      check("ovf_flag", 32'(err_overflow), 1);
      check("ovf_count_held", 32'(count), 8);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("drain_valid", 32'(out_valid), 1);
         check("drain_data", 32'(out_data), 32'(i));
         tick();
      end
      check("drain_empty", 32'(out_valid), 0);

      // Steady streaming with pointer wrap.
      issue_valid = 1'b1;
      out_ready   = 1'b1;
      pops        = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) pops++;
         tick();
      end
      check("stream_throughput", 32'(pops), 34);
      check("stream_credits", 32'(credits), 2);
      issue_valid = 1'b0;
      repeat (10) tick();

      // Issue and pop together while credits are exhausted.
      out_ready   = 1'b0;
      issue_valid = 1'b1;
      repeat (8) tick();
      issue_valid = 1'b0;
      repeat (7) tick();
      issue_valid = 1'b1;
      out_ready   = 1'b1;
      check("zero_credits", 32'(credits), 0);
      check("zero_blocked", 32'(issue_ready), 0);
      tick();
      check("zero_pop_credit", 32'(credits), 1);
      check("zero_ready_again", 32'(issue_ready), 1);
      tick();
      check("zero_fire_and_pop", 32'(credits), 1);
      issue_valid = 1'b0;
      repeat (20) tick();

      // Reset with four queued and three in flight.
      out_ready   = 1'b0;
      issue_valid = 1'b1;
      repeat (7) tick();
      issue_valid = 1'b0;
      repeat (2) tick();
      check("pre_rst_count", 32'(count), 4);
      check("pre_rst_credits", 32'(credits), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("post_rst_credits", 32'(credits), 8);
      check("post_rst_count", 32'(count), 0);
      check("post_rst_out_valid", 32'(out_valid), 0);
      check("post_rst_flags", {30'd0, err_overflow, err_unexpected}, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("post_rst_no_stale", 32'(out_valid), 0);
      end

      // Unexpected result with nothing in flight.
      out_ready = 1'b0;
      inj_valid = 1'b1;
      inj_data  = 8'hAA;
      tick();
      inj_valid = 1'b0;
      check("unx_flag", 32'(err_unexpected), 1);
      check("unx_out_valid", 32'(out_valid), 1);
      check("unx_out_data", 32'(out_data), 32'hAA);
      check("unx_credits_kept", 32'(credits), 8);
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("unx_sticky", 32'(err_unexpected), 1);
      end
      check("unx_ovf_clear", 32'(err_overflow), 0);

      // Random issue/backpressure from a clean reset.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 400; i++) begin
         issue_valid = 1'($urandom_range(0, 1));
         out_ready   = ($urandom_range(0, 3) != 0);
         tick();
      end
      issue_valid = 1'b0;
      out_ready   = 1'b1;
      repeat (20) tick();
      check("rand_final_credits", 32'(credits), 8);
      check("rand_final_count", 32'(count), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
